seq_or_stim: RTL and testbench
==============================

SEQ_OR_STIM -- requirements
Module: seq_or_stim

Interface
REQ-001 SHALL have parameter GAP_W, default 3, width of the gap field (idle cycles between trigger and tail).
REQ-002 SHALL have parameter RPT_W, default 4, width of the burst-repeat field and burst counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to run one programmed burst train; sampled only in IDLE.
REQ-006 SHALL have port mode  input  2  thread select: 00 a-thread, 01 c-thread, 10 both threads, 11 alternate a/c per burst.
REQ-007 SHALL have port gap  input  GAP_W  idle cycles between TRIG and TAIL.
REQ-008 SHALL have port rpt  input  RPT_W  number of bursts in the train.
REQ-009 SHALL have port a  output  1  registered first-thread trigger to downstream checker.
REQ-010 SHALL have port c  output  1  registered second-thread trigger / trailing qualifier.
REQ-011 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-012 SHALL have port done  output  1  one-cycle pulse at train completion.
REQ-013 SHALL have port burst_cnt  output  RPT_W  completed bursts in the current or last train.

Function
REQ-014 SHALL implement FSM states IDLE, TRIG, GAP, TAIL, DONE; all outputs registered (driven from next-state logic).
REQ-015 SHALL, in IDLE with start=1, latch mode, gap, rpt; clear burst_cnt to 0; go to TRIG, or to DONE if rpt=0.
REQ-016 SHALL ignore start in every state other than IDLE; latched fields are not updated mid-train.
REQ-017 SHALL make a/c visible the cycle after start is sampled (latency 1).
REQ-018 SHALL, in TRIG (1 cycle), drive: mode 00 a=1,c=0; mode 01 a=0,c=1; mode 10 a=1,c=1; mode 11 a=1,c=0 when burst_cnt is even, a=0,c=1 when odd.
REQ-019 SHALL leave TRIG for GAP when latched gap>0, else directly for TAIL.
REQ-020 SHALL hold GAP for exactly latched gap cycles with a=0,c=0, using a GAP_W down-counter loaded on TRIG exit.
REQ-021 SHALL, in TAIL (1 cycle), drive a=0,c=1 and increment burst_cnt by 1.
REQ-022 SHALL leave TAIL for DONE when incremented burst_cnt equals latched rpt, else for TRIG.
REQ-023 SHALL, in DONE (1 cycle), drive done=1, a=0, c=0, busy=1; then go to IDLE.
REQ-024 SHALL drive a=0, c=0, done=0, busy=0 in IDLE; burst_cnt holds its last value.
REQ-025 SHALL produce burst length 2+gap cycles and train length rpt*(2+gap)+1 cycles from first busy to done inclusive.
REQ-026 SHALL accept a new start in the cycle after done (IDLE), giving back-to-back trains with one idle cycle.
REQ-027 SHALL support max values rpt=2^RPT_W-1 and gap=2^GAP_W-1 without counter wrap or early termination.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, go to IDLE and set a=0, c=0, busy=0, done=0, burst_cnt=0, latched fields=0.
REQ-029 SHALL give reset priority over start and over every state transition, including mid-GAP and DONE.
REQ-030 SHALL require one reset-free edge with start=1 after reset deassertion before TRIG is entered.

Verification
REQ-031 SHALL pass: mode=00, gap=1, rpt=1, start pulse -> a=1 (1 cycle), a=c=0 (1), c=1 (1), done=1 next cycle; burst_cnt=1.
REQ-032 SHALL pass: mode=11, gap=0, rpt=4 -> TRIG sequence a,c,a,c, each followed by a TAIL c=1; done after 9 busy cycles; burst_cnt=4.
REQ-033 SHALL pass: mode=10, gap=7, rpt=15 -> a=c=1 in every TRIG, 7 idle gap cycles, done after 136 busy cycles; burst_cnt=15.
REQ-034 SHALL pass: rpt=0 with start -> busy=1 for one cycle with done=1; a and c never asserted; burst_cnt=0.
REQ-035 SHALL pass: start held high during a train -> no restart, no relatch; a new train starts only on the IDLE cycle after done.
REQ-036 SHALL pass: reset asserted in GAP of burst 2 (mode=01, gap=3, rpt=3) -> next edge all outputs 0, IDLE; no done pulse.

Source files
------------

// File: rtl/seq_or_stim.sv
// seq_or_stim: programmable burst-train stimulus generator driving a/c trigger threads
module seq_or_stim #(
  parameter int GAP_W = 3,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [GAP_W-1:0] gap,
  input  logic [RPT_W-1:0] rpt,
  output logic             a,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [RPT_W-1:0] burst_cnt
);
  typedef enum logic [2:0] {IDLE, TRIG, GAP, TAIL, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic [RPT_W-1:0] rpt_q, rpt_d, cnt_q, cnt_d;
  logic a_d, c_d, busy_d, done_d;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    gap_d = gap_q;
    rpt_d = rpt_q;
    gcnt_d = gcnt_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
        gap_d = gap;
        rpt_d = rpt;
        cnt_d = '0;
        state_d = rpt == '0 ? DONE : TRIG;
      end
      TRIG: begin
        state_d = gap_q != '0 ? GAP : TAIL;
        gcnt_d = gap_q - GAP_W'(1);
      end
      GAP: begin
        state_d = gcnt_q == '0 ? TAIL : GAP;
        gcnt_d = gcnt_q == '0 ? gcnt_q : gcnt_q - GAP_W'(1);
      end
      TAIL: state_d = cnt_q == rpt_q ? DONE : TRIG;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // the count is registered on entry to TAIL so it reads as completed during TAIL
    if (state_d == TAIL) cnt_d = cnt_q + RPT_W'(1);
    a_d = state_d == TRIG && (mode_d == 2'b00 || mode_d == 2'b10 || (mode_d == 2'b11 && !cnt_d[0]));
    c_d = state_d == TAIL || (state_d == TRIG && (mode_d == 2'b01 || mode_d == 2'b10 || (mode_d == 2'b11 && cnt_d[0])));
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q <= '0;
      gap_q <= '0;
      rpt_q <= '0;
      gcnt_q <= '0;
      cnt_q <= '0;
      a <= 1'b0;
      c <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      gap_q <= gap_d;
      rpt_q <= rpt_d;
      gcnt_q <= gcnt_d;
      cnt_q <= cnt_d;
      a <= a_d;
      c <= c_d;
      busy <= busy_d;
      done <= done_d;
    end
  end
  assign burst_cnt = cnt_q;
endmodule

// File: tb/tb_seq_or_stim.sv
// tb_seq_or_stim: table vectors, directed corner sequences and random trains vs a burst-list model
module tb_seq_or_stim;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] mode = '0;
  logic [2:0] gap = '0;
  logic [3:0] rpt = '0;
  logic a, c, busy, done;
  logic [3:0] burst_cnt;
  int nchk = 0, nerr = 0;
  seq_or_stim dut (.clk(clk), .reset(reset), .start(start), .mode(mode), .gap(gap), .rpt(rpt),
                   .a(a), .c(c), .busy(busy), .done(done), .burst_cnt(burst_cnt));
  always #5 clk = ~clk;
  typedef struct packed {logic a, c, busy, done; logic [3:0] cnt;} obs_t;
  typedef struct {logic [1:0] m; int g, r, len, na, nc;} vec_t;
  obs_t exp_q[$];
  vec_t tbl[7];
  function automatic obs_t mk(logic ea, logic ec, logic eb, logic ed, logic [3:0] en);
    return {ea, ec, eb, ed, en};
  endfunction
  // each burst is TRIG, gap idle cycles, TAIL; the train closes with one DONE cycle
  function automatic void build(logic [1:0] m, int g, int r);
    exp_q.delete();
    for (int b = 0; b < r; b++) begin
      logic ta = m == 2'd0 || m == 2'd2 || (m == 2'd3 && b % 2 == 0);
      logic tc = m == 2'd1 || m == 2'd2 || (m == 2'd3 && b % 2 == 1);
      exp_q.push_back(mk(ta, tc, 1'b1, 1'b0, 4'(b)));
      for (int k = 0; k < g; k++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'(b)));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'(b + 1)));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'(r)));
  endfunction
  task automatic chk(string nm, obs_t e);
    obs_t got = {a, c, busy, done, burst_cnt};
    nchk++;
    if (got !== e) begin
      nerr++;
      $display("FAIL %s t=%0t: got a=%b c=%b busy=%b done=%b cnt=%0d, want a=%b c=%b busy=%b done=%b cnt=%0d",
               nm, $time, got.a, got.c, got.busy, got.done, got.cnt, e.a, e.c, e.busy, e.done, e.cnt);
    end
  endtask
  task automatic chk_int(string nm, int got, int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask
  task automatic kick(logic [1:0] m, int g, int r);
    start = 1'b1;
    mode = m;
    gap = 3'(g);
    rpt = 4'(r);
  endtask
  // fields are scrambled every cycle after launch to prove they are not relatched
  task automatic check_n(int n, bit hold, string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(nm, exp_q[i]);
      start = hold;
      mode = 2'($urandom);
      gap = 3'($urandom);
      rpt = 4'($urandom);
    end
  endtask
  task automatic run(logic [1:0] m, int g, int r, bit hold, string nm);
    build(m, g, r);
    kick(m, g, r);
    check_n(exp_q.size(), hold, nm);
    @(negedge clk);
    chk({nm, "_idle"}, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'(r)));
  endtask
  initial begin
    int nb, na, nc, seen;
    tbl[0] = '{2'd0, 1, 1, 4, 1, 1};
    tbl[1] = '{2'd3, 0, 4, 9, 2, 6};
    tbl[2] = '{2'd2, 7, 15, 136, 15, 30};
    tbl[3] = '{2'd2, 5, 0, 1, 0, 0};
    tbl[4] = '{2'd1, 2, 2, 9, 0, 4};
    tbl[5] = '{2'd0, 0, 15, 31, 15, 15};
    tbl[6] = '{2'd3, 2, 3, 13, 2, 4};
    repeat (2) @(negedge clk);
    chk("reset_state", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    foreach (tbl[i]) begin
      kick(tbl[i].m, tbl[i].g, tbl[i].r);
      nb = 0; na = 0; nc = 0; seen = 0;
      for (int k = 0; k < 300 && seen == 0; k++) begin
        @(negedge clk);
        start = 1'b0;
        nb += int'(busy);
        na += int'(a);
        nc += int'(c);
        seen = int'(done);
      end
      chk_int($sformatf("tbl%0d_done_seen", i), seen, 1);
      chk_int($sformatf("tbl%0d_busy_len", i), nb, tbl[i].len);
      chk_int($sformatf("tbl%0d_a_pulses", i), na, tbl[i].na);
      chk_int($sformatf("tbl%0d_c_pulses", i), nc, tbl[i].nc);
      chk_int($sformatf("tbl%0d_burst_cnt", i), int'(burst_cnt), tbl[i].r);
      @(negedge clk);
    end
    run(2'd0, 1, 1, 1'b0, "req031");
    run(2'd3, 0, 4, 1'b0, "req032");
    run(2'd2, 7, 15, 1'b0, "req033");
    run(2'd1, 4, 0, 1'b0, "req034");
    run(2'd1, 2, 2, 1'b1, "hold_a");
    run(2'd3, 1, 3, 1'b0, "hold_b");
    start = 1'b0;
    @(negedge clk);
    build(2'd1, 3, 3);
    kick(2'd1, 3, 3);
    check_n(7, 1'b0, "req036_pre");
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("req036_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    reset = 1'b0;
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("req036_quiet", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    end
    for (int t = 0; t < 25; t++) begin
      int rm = $urandom_range(0, 3), rg = $urandom_range(0, 7), rr = $urandom_range(0, 15);
      run(2'(rm), rg, rr, 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
